// File: rtl/instruction_execute.sv
// RV32I execute stage: ALU, branch resolve and the EX/MEM pipeline register.
// Define INSTRUCTION_EXECUTE_MUL_EN to add an iterative shift-add multiplier that stalls the front end.
module instruction_execute #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            mem_re_in,
  input  logic            mem_we_in,
  input  logic            reg_file_write_in,
  input  logic            branch_instruction_in,
  input  logic [1:0]      alu_op_in,
  input  logic [1:0]      select_mux_1_in,
  input  logic [1:0]      select_mux_2_in,
  input  logic [1:0]      select_mux_4_in,
  input  logic [XLEN-1:0] reg_a_in,
  input  logic [XLEN-1:0] reg_b_in,
  input  logic [XLEN-1:0] immediate_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [6:0]      funct7e3_in,
  input  logic [2:0]      funct3_in,
  input  logic [4:0]      rd_in,
  output logic            mem_re_out,
  output logic            mem_we_out,
  output logic            reg_file_write_out,
  output logic [1:0]      select_mux_2_out,
  output logic [1:0]      select_mux_4_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_ex_mem,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            ex_stall
);

  if (MUL_CYCLES != XLEN) begin : g_bad_cfg
    $error("MUL_CYCLES must equal XLEN");
  end

  logic [XLEN-1:0] op_b, alu_res, ex_result;
  logic            br_cond;

  assign op_b = (select_mux_1_in == 2'b01) ? immediate_in : reg_b_in;

  always_comb begin
    alu_res = reg_a_in + op_b;
    if (alu_op_in == 2'b10) begin
      case (funct3_in)
        3'b000: if (funct7e3_in == 7'b0100000) alu_res = reg_a_in - op_b;
        3'b001: alu_res = reg_a_in << op_b[4:0];
        3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(reg_a_in) < $signed(op_b)};
        3'b011: alu_res = {{(XLEN-1){1'b0}}, reg_a_in < op_b};
        3'b100: alu_res = reg_a_in ^ op_b;
        3'b101: begin
          if (funct7e3_in == 7'b0000000)      alu_res = reg_a_in >> op_b[4:0];
          else if (funct7e3_in == 7'b0100000) alu_res = $signed(reg_a_in) >>> op_b[4:0];
        end
        3'b110: alu_res = reg_a_in | op_b;
        3'b111: alu_res = reg_a_in & op_b;
        default: ;
      endcase
    end
  end

  // Branches always compare the two register operands, never the immediate.
  always_comb begin
    br_cond = 1'b0;
    case (funct3_in)
      3'b000: br_cond = (reg_a_in == reg_b_in);
      3'b001: br_cond = (reg_a_in != reg_b_in);
      3'b100: br_cond = ($signed(reg_a_in) <  $signed(reg_b_in));
      3'b101: br_cond = ($signed(reg_a_in) >= $signed(reg_b_in));
      3'b110: br_cond = (reg_a_in <  reg_b_in);
      3'b111: br_cond = (reg_a_in >= reg_b_in);
      default: br_cond = 1'b0;
    endcase
  end

`ifdef INSTRUCTION_EXECUTE_MUL_EN
  localparam int CW = $clog2(MUL_CYCLES);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t      state, state_nxt;
  logic            mul_req, stall_raw;
  logic [XLEN-1:0] mcand, mplier, acc;
  logic [CW-1:0]   cnt;

  assign mul_req = (alu_op_in == 2'b10) && (funct7e3_in == 7'b0000001) && (funct3_in == 3'b000);

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    case (state)
      IDLE: if (mul_req) begin
        stall_raw = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        stall_raw = 1'b1;
        if (cnt == CW'(MUL_CYCLES-1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by reset so the stall drops the moment reset asserts, even with a mul held at the inputs.
  assign ex_stall = stall_raw & reset_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == IDLE && mul_req) begin
      mcand  <= reg_a_in;
      mplier <= reg_b_in;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign ex_result = (state == DONE) ? acc : alu_res;
`else
  assign ex_stall  = 1'b0;
  assign ex_result = alu_res;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || ex_stall) begin
      mem_re_out         <= 1'b0;
      mem_we_out         <= 1'b0;
      reg_file_write_out <= 1'b0;
      select_mux_2_out   <= '0;
      select_mux_4_out   <= '0;
      alu_result_out     <= '0;
      store_data_out     <= '0;
      rd_ex_mem          <= '0;
      branch_taken       <= 1'b0;
      branch_target      <= '0;
    end else begin
      mem_re_out         <= mem_re_in;
      mem_we_out         <= mem_we_in;
      reg_file_write_out <= reg_file_write_in;
      select_mux_2_out   <= select_mux_2_in;
      select_mux_4_out   <= select_mux_4_in;
      alu_result_out     <= ex_result;
      store_data_out     <= reg_b_in;
      rd_ex_mem          <= reg_file_write_in ? rd_in : 5'd0;
      branch_taken       <= br_cond & branch_instruction_in;
      branch_target      <= pc_in + immediate_in;
    end
  end

endmodule

// File: doc/instruction_execute.md
# instruction_execute

Execute stage of the five-stage RV32I pipeline. It consumes the ID/EX register outputs of the decode stage and computes the ALU result, store data and branch outcome. It registers these into the EX/MEM pipeline register and returns `rd_ex_mem` and `branch_taken` to the decode-stage hazard logic. An optional iterative multiplier adds `mul` support by stalling the front end.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `MUL_CYCLES`, 32: shift-add iterations per multiply. Equals `XLEN`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_re_in`, `mem_we_in`, `reg_file_write_in`, `branch_instruction_in` in 1 each: ID/EX control bits.
- `alu_op_in` in 2: 00/01 = add; 10 = R-type decode via funct fields; 11 = add.
- `select_mux_1_in` in 2: 01 selects `immediate_in` as ALU operand B; any other value selects `reg_b_in`.
- `select_mux_2_in`, `select_mux_4_in` in 2 each: writeback/store selects, passed through.
- `reg_a_in`, `reg_b_in`, `immediate_in`, `pc_in` in 32 each: ID/EX data.
- `funct7e3_in` in 7: instr[31:25] (funct7).
- `funct3_in` in 3: instr[14:12].
- `rd_in` in 5: instr[11:7].
- `mem_re_out`, `mem_we_out`, `reg_file_write_out` out 1 each: EX/MEM control.
- `select_mux_2_out`, `select_mux_4_out` out 2 each: EX/MEM selects.
- `alu_result_out` out 32: ALU result or memory address.
- `store_data_out` out 32: `reg_b_in`, registered.
- `rd_ex_mem` out 5: destination register. Forced to 0 whenever `reg_file_write_out` is 0.
- `branch_taken` out 1: registered branch outcome.
- `branch_target` out 32: registered `pc_in + immediate_in`.
- `ex_stall` out 1: combinational. Upstream must hold PC, IF/ID and ID/EX while it is high.

## Operation
- Operand A = `reg_a_in`. Operand B is selected by `select_mux_1_in`.
- R-type decode on {funct7, funct3}:
  - 0000000/000 add
  - 0100000/000 sub
  - 000/001 sll, using B[4:0]
  - 010 slt, signed
  - 011 sltu
  - 100 xor
  - 0000000/101 srl
  - 0100000/101 sra
  - 110 or
  - 111 and
  - Any other combination gives add.
- All arithmetic is modulo 2^32. Carry and overflow are discarded.
- Branch compare of `reg_a_in` against `reg_b_in` by funct3:
  - 000 beq
  - 001 bne
  - 100 blt
  - 101 bge
  - 110 bltu
  - 111 bgeu
  - 010 and 011 never take.
- `branch_taken` = compare result AND `branch_instruction_in`.
- A bubble (all control inputs 0) produces all-zero control outputs and `branch_taken` = 0.
- Multiply FSM (only with `MUL_EN`), states IDLE, BUSY, DONE:
  - The multiply condition is `alu_op_in`=10, funct7=0000001, funct3=000.
  - IDLE, multiply present: `ex_stall`=1. At the next edge, latch A and B, clear the accumulator and counter, go to BUSY.
  - BUSY: `ex_stall`=1. Each edge, if multiplier bit 0 is set, add the multiplicand to the accumulator. Shift the multiplicand left and the multiplier right, then increment the counter. After the edge where the counter reaches `MUL_CYCLES`-1, go to DONE.
  - DONE: `ex_stall`=0. The EX/MEM register loads the low 32 product bits with the held control. The FSM returns to IDLE on the same edge.
  - While `ex_stall`=1, the EX/MEM register loads a bubble: control outputs 0, `rd_ex_mem`=0, `branch_taken`=0.
- Reset asserted mid-multiply: the FSM returns to IDLE, the partial product is discarded and `ex_stall` drops immediately.

## Timing
- Reset values: every output is 0, FSM is in IDLE, `ex_stall`=0.
- Non-multiply instruction: inputs sampled at edge N, all outputs valid after edge N. Latency is 1 cycle.
- `branch_taken` and `branch_target` are valid in the same cycle as the other EX/MEM outputs. Decode holds `branch_instruction_id_ex` off this result.
- Multiply first presented in cycle 0:
  - `ex_stall` is high for exactly 33 cycles: 1 in IDLE plus 32 in BUSY.
  - The product appears on `alu_result_out` after the 34th edge.
  - Back-to-back multiplies each take the full 34 edges. No overlap.
- Inputs must stay stable while `ex_stall`=1. Changes during that time are unspecified behaviour.

## Configuration
- `INSTRUCTION_EXECUTE_MUL_EN`
  - Defined: the multiplier FSM is compiled in, with the behaviour above.
  - Undefined: funct7=0000001 decodes as add, `ex_stall` is tied to 0, and no FSM registers exist.

## Test plan
- Reset: hold `reset_n`=0 with random inputs. Every output must be 0; release, first edge with bubble inputs, outputs stay 0.
- R-type: A=5, B=-3, `alu_op_in`=10, sub, `rd_in`=7, `reg_file_write_in`=1. After one edge, `alu_result_out`=8 and `rd_ex_mem`=7. Then slt gives 0 and sltu gives 1.
- Load: A=0x100, imm=0x14, `select_mux_1_in`=01, `mem_re_in`=1. Required: `alu_result_out`=0x114, `mem_re_out`=1, `store_data_out` equal to `reg_b_in`.
- Branch:
  - blt with A=-1, B=0, `pc_in`=0x40, imm=0x10: `branch_taken`=1, `branch_target`=0x50.
  - Same case with `branch_instruction_in`=0: `branch_taken`=0.
- Multiply (`MUL_EN`): A=7, B=-3. Required: `ex_stall` high for exactly 33 cycles, bubbles on EX/MEM meanwhile, then `alu_result_out`=0xFFFFFFEB.
- Reset mid-multiply at BUSY cycle 10: `ex_stall` drops asynchronously. A following add with A=1, B=1 completes in 1 cycle with result 2.
